// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and level IRQ.
// Ports: clk_i/rst_ni, uart_req/we/be/addr/wdata in, uart_rvalid/rdata/err out, tx_o, irq_o.
module uart_tx_device #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int FifoDepth    = 8,
    parameter int DefaultDiv   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    uart_req_i,
    input  logic                    uart_we_i,
    input  logic [DataWidth/8-1:0]  uart_be_i,
    input  logic [AddressWidth-1:0] uart_addr_i,
    input  logic [DataWidth-1:0]    uart_wdata_i,
    output logic                    uart_rvalid_o,
    output logic [DataWidth-1:0]    uart_rdata_o,
    output logic                    uart_err_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int LvlW = PtrW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      clkdiv_q;
    logic [1:0]       ctrl_q;
    logic             irq_q;
    logic             rvalid_q;
    logic             err_q, err_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic [7:0]       mem_q [FifoDepth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [LvlW-1:0]  level_q, level_d;

    logic [9:0]       offset;
    logic             full, empty, push, pop;
    logic             div_we, ctrl_we;
    logic [31:0]      rval;
    logic [15:0]      reload;
    logic             bit_end;
    logic             unused;

    assign offset = uart_addr_i[9:0];
    assign full   = (level_q == LvlW'(FifoDepth));
    assign empty  = (level_q == '0);
    assign unused = ^{uart_be_i, uart_addr_i[AddressWidth-1:10],
                      offset[1:0], uart_wdata_i[DataWidth-1:16]};

    // Bus decode; a full FIFO still accepts a byte when a pop frees a slot.
    always_comb begin
        err_d   = 1'b0;
        push    = 1'b0;
        div_we  = 1'b0;
        ctrl_we = 1'b0;
        rval    = 32'h0;
        if (uart_req_i) begin
            if (|offset[9:4]) begin
                err_d = 1'b1;
            end else if (uart_we_i) begin
                case (offset[3:2])
                    2'd0: begin
                        if (full && !pop) err_d = 1'b1;
                        else              push  = 1'b1;
                    end
                    2'd1:    err_d   = 1'b1;
                    2'd2:    div_we  = 1'b1;
                    default: ctrl_we = 1'b1;
                endcase
            end else begin
                case (offset[3:2])
                    2'd0:    rval = 32'h0;
                    2'd1:    rval = {16'h0, 8'(level_q), 5'h0,
                                     (state_q != IDLE), empty, full};
                    2'd2:    rval = {16'h0, clkdiv_q};
                    default: rval = {30'h0, ctrl_q};
                endcase
            end
        end
        rdata_d = err_d ? '0 : DataWidth'(rval);
    end

    // A zero divider behaves as one cycle per bit.
    assign reload  = ((clkdiv_q == 16'h0) ? 16'h1 : clkdiv_q) - 16'h1;
    assign bit_end = (cnt_q == 16'h0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_q[0] && !empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    cnt_d   = reload;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = reload;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'h1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'h1;
                end
            end
            default: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data waits.
                    if (ctrl_q[0] && !empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        cnt_d   = reload;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'h1;
                end
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= 16'h0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h0;
            clkdiv_q <= 16'(DefaultDiv);
            ctrl_q   <= 2'b00;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            for (int i = 0; i < FifoDepth; i++) mem_q[i] <= 8'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            irq_q    <= ctrl_q[1] & empty & (state_q == IDLE);
            rvalid_q <= uart_req_i;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            level_q  <= level_d;
            if (div_we)  clkdiv_q <= uart_wdata_i[15:0];
            if (ctrl_we) ctrl_q   <= uart_wdata_i[1:0];
            if (push) begin
                mem_q[wptr_q] <= uart_wdata_i[7:0];
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    assign uart_rvalid_o = rvalid_q;
    assign uart_rdata_o  = rdata_q;
    assign uart_err_o    = err_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed self-checking bench for uart_tx_device.
// Drives bus accesses and checks register reads and tx_o/irq_o waveforms.
module tb_uart_tx_device;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lows;
    logic [7:0]  bytes [8];

    always #5 clk = ~clk;

    uart_tx_device dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .uart_req_i   (req),
        .uart_we_i    (we),
        .uart_be_i    (be),
        .uart_addr_i  (addr),
        .uart_wdata_i (wdata),
        .uart_rvalid_o(rvalid),
        .uart_rdata_o (rdata),
        .uart_err_o   (err),
        .tx_o         (tx),
        .irq_o        (irq)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rvalid", {31'h0, rvalid}, 32'h1);
        r = rdata;
        e = err;
    endtask

    task automatic wait_fall(output logic found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Starts on the already-sampled first start-bit cycle.
    task automatic frames(input int n, input int div, input bit irq_low,
                          input string tag);
        logic [7:0] b;
        int j;
        logic e;
        for (int f = 0; f < n; f++) begin
            b = bytes[f];
            for (int i = 0; i < 10 * div; i++) begin
                if (f > 0 || i > 0) @(negedge clk);
                j = i / div;
                if (j == 0)      e = 1'b0;
                else if (j == 9) e = 1'b1;
                else             e = b[j-1];
                chk(tag, {31'h0, tx}, {31'h0, e});
                if (irq_low) chk("irq_busy", {31'h0, irq}, 32'h0);
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_ni = 1'b1;
        bus(1'b0, 32'h4, 0, rd, er);
        chk("rst_status", rd, 32'h2);
        chk("rst_status_err", {31'h0, er}, 32'h0);
        bus(1'b0, 32'h8, 0, rd, er);
        chk("rst_clkdiv", rd, 32'h10);
        bus(1'b0, 32'hC, 0, rd, er);
        chk("rst_ctrl", rd, 32'h0);
        chk("rst_ctrl_err", {31'h0, er}, 32'h0);
        chk("idle_tx", {31'h0, tx}, 32'h1);

        // Single 0x55 frame at 4 cycles per bit
        bus(1'b1, 32'h8, 32'h4, rd, er);
        bus(1'b1, 32'hC, 32'h1, rd, er);
        bus(1'b1, 32'h0, 32'h55, rd, er);
        chk("tx_wr_err", {31'h0, er}, 32'h0);
        wait_fall(ok);
        chk("start_55", {31'h0, ok}, 32'h1);
        bytes[0] = 8'h55;
        frames(1, 4, 1'b0, "frame_55");
        @(negedge clk);
        chk("after_55_tx", {31'h0, tx}, 32'h1);
        bus(1'b0, 32'h4, 0, rd, er);
        chk("after_55_status", rd, 32'h2);

        // Fill FIFO with transmitter disabled, then overflow
        bus(1'b1, 32'hC, 32'h0, rd, er);
        bus(1'b1, 32'h8, 32'h2, rd, er);
        bytes[0] = 8'h01; bytes[1] = 8'h80;
        bytes[2] = 8'hFF; bytes[3] = 8'h00;
        bytes[4] = 8'hA5; bytes[5] = 8'h5A;
        bytes[6] = 8'h3C; bytes[7] = 8'hC3;
        for (int k = 0; k < 8; k++) bus(1'b1, 32'h0, {24'h0, bytes[k]}, rd, er);
        bus(1'b0, 32'h4, 0, rd, er);
        chk("full_status", rd, 32'h0801);
        bus(1'b1, 32'h0, 32'hEE, rd, er);
        chk("overflow_err", {31'h0, er}, 32'h1);
        chk("overflow_rdata", rd, 32'h0);
        bus(1'b0, 32'h4, 0, rd, er);
        chk("overflow_status", rd, 32'h0801);
        chk("disabled_tx", {31'h0, tx}, 32'h1);
        bus(1'b1, 32'hC, 32'h1, rd, er);
        wait_fall(ok);
        chk("start_burst", {31'h0, ok}, 32'h1);
        frames(8, 2, 1'b0, "burst");
        @(negedge clk);
        chk("after_burst_tx", {31'h0, tx}, 32'h1);
        bus(1'b0, 32'h4, 0, rd, er);
        chk("after_burst_status", rd, 32'h2);

        // Error responses
        bus(1'b0, 32'h10, 0, rd, er);
        chk("err_10", {31'h0, er}, 32'h1);
        chk("err_10_rdata", rd, 32'h0);
        bus(1'b0, 32'h3FC, 0, rd, er);
        chk("err_3fc", {31'h0, er}, 32'h1);
        chk("err_3fc_rdata", rd, 32'h0);
        bus(1'b1, 32'h4, 32'hFFFF, rd, er);
        chk("err_wr_status", {31'h0, er}, 32'h1);
        bus(1'b1, 32'h18, 32'h7, rd, er);
        chk("err_wr_18", {31'h0, er}, 32'h1);
        bus(1'b0, 32'h4, 0, rd, er);
        chk("err_nochange_status", rd, 32'h2);
        bus(1'b0, 32'h8, 0, rd, er);
        chk("err_nochange_div", rd, 32'h2);
        bus(1'b0, 32'hC, 0, rd, er);
        chk("err_nochange_ctrl", rd, 32'h1);

        // Interrupt behaviour at one cycle per bit
        bus(1'b1, 32'hC, 32'h0, rd, er);
        bus(1'b1, 32'h8, 32'h1, rd, er);
        bus(1'b1, 32'h0, 32'hA5, rd, er);
        bus(1'b1, 32'hC, 32'h3, rd, er);
        wait_fall(ok);
        chk("start_a5", {31'h0, ok}, 32'h1);
        bytes[0] = 8'hA5;
        frames(1, 1, 1'b1, "frame_a5");
        @(negedge clk);
        chk("irq_stop_end", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, 32'h1);
        bus(1'b1, 32'h0, 32'h00, rd, er);
        @(negedge clk);
        chk("irq_clear", {31'h0, irq}, 32'h0);
        repeat (20) @(negedge clk);

        // Reset in the middle of a frame
        bus(1'b1, 32'h8, 32'h8, rd, er);
        bus(1'b1, 32'h0, 32'h00, rd, er);
        wait_fall(ok);
        chk("start_rst", {31'h0, ok}, 32'h1);
        repeat (12) @(negedge clk);
        chk("data_low", {31'h0, tx}, 32'h0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_tx", {31'h0, tx}, 32'h1);
        chk("async_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        bus(1'b0, 32'h4, 0, rd, er);
        chk("post_rst_status", rd, 32'h2);
        bus(1'b0, 32'h8, 0, rd, er);
        chk("post_rst_div", rd, 32'h10);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_no_frame", lows, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
